// File: rtl/mem_req_responder_if.sv
// ----------------------------------------------------------------------------
// mem_req_responder_if
// Bundles the two CPU memory initiators (instruction fetch port and data
// port) into one interface shared by the CPU side and the memory responder.
//
// Signals:
//   i_req    instruction read request, held until i_ack
//   i_addr   instruction byte address (bit 0 ignored)
//   i_ack    one-cycle acknowledge, i_rdata valid in that cycle
//   i_rdata  instruction word
//   d_req    data request, held until d_ack
//   d_wr     1 = write, 0 = read
//   d_addr   data byte address (bit 0 ignored)
//   d_wdata  write data
//   d_ack    one-cycle acknowledge, d_rdata valid in that cycle
//   d_rdata  read data (0x0000 on write acknowledges)
//
// Modports:
//   master   CPU side, drives requests
//   slave    memory responder side, drives acknowledges and read data
// ----------------------------------------------------------------------------
interface mem_req_responder_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  i_ack, i_rdata, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output i_ack, i_rdata, d_ack, d_rdata
  );
endinterface

// File: rtl/mem_req_responder.sv
// ----------------------------------------------------------------------------
// mem_req_responder
// Memory-side responder for the pipelined CPU. Arbitrates round-robin between
// the instruction fetch port and the data port and models a multi-cycle
// unified 16-bit word memory. Every request completes with a one-cycle ack.
//
// Parameters:
//   LATENCY     cycles from acceptance to acknowledge (2..15)
//   DEPTH_LOG2  log2 of the number of 16-bit words
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (FSM, counter, outputs; not the array)
//   bus   slave side of mem_req_responder_if (both initiator ports)
//   busy  high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mem_req_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_req_responder_if.slave   bus,
  output logic                 busy
);

  localparam int         WORDS      = 1 << DEPTH_LOG2;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);
  localparam logic       GRANT_I    = 1'b0;
  localparam logic       GRANT_D    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t                state;
  state_t                state_next;

  logic                  grant_q;
  logic                  last_grant_q;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] index_q;
  logic [15:0]           wdata_q;
  logic [15:0]           rdata_q;
  logic [3:0]            count_q;

  logic                  accept;
  logic                  pick_d;
  logic                  access;
  logic                  unused_addr_bits;

  logic [15:0]           mem [0:WORDS-1];

  // Only addr[DEPTH_LOG2:1] selects a word; the rest wraps away.
  assign unused_addr_bits = ^{bus.i_addr, bus.d_addr};

  // D wins when it is the only requester, or on a tie when I was served last.
  assign accept = (state == IDLE) && (bus.i_req || bus.d_req);
  assign pick_d = bus.d_req && (!bus.i_req || (last_grant_q == GRANT_I));
  assign access = (state == WAIT) && (count_q == 4'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (count_q == 4'd1) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction latch, latency counter, read-data register and arbitration
  // history. The array access happens on the edge leaving WAIT, so a reset
  // before that edge aborts the transaction with no side effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_I;
      wr_q         <= 1'b0;
      index_q      <= '0;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
      count_q      <= 4'd0;
    end else begin
      if (accept) begin
        grant_q <= pick_d;
        index_q <= pick_d ? bus.d_addr[DEPTH_LOG2:1] : bus.i_addr[DEPTH_LOG2:1];
        wr_q    <= pick_d && bus.d_wr;
        wdata_q <= bus.d_wdata;
        count_q <= COUNT_LOAD;
      end else if (state == WAIT) begin
        count_q <= count_q - 4'd1;
      end

      if (access) begin
        rdata_q <= wr_q ? 16'h0000 : mem[index_q];
      end

      if (state == ACK) begin
        last_grant_q <= grant_q;
      end
    end
  end

  // Word array: never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q) begin
      mem[index_q] <= wdata_q;
    end
  end

  // Outputs decode registered state only; rdata is zero outside the ack.
  always_comb begin
    busy        = (state != IDLE);
    bus.i_ack   = 1'b0;
    bus.d_ack   = 1'b0;
    bus.i_rdata = 16'h0000;
    bus.d_rdata = 16'h0000;
    if (state == ACK) begin
      if (grant_q == GRANT_D) begin
        bus.d_ack   = 1'b1;
        bus.d_rdata = rdata_q;
      end else begin
        bus.i_ack   = 1'b1;
        bus.i_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_req_responder
// Self-checking bench for mem_req_responder. A reference model holds the
// memory as a plain array and predicts ack cycles, read data, busy and the
// arbitration order arithmetically from request times and the latency.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_req_responder;

  localparam int LAT   = 4;
  localparam int DL    = 10;
  localparam int WORDS = 1 << DL;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mem_req_responder_if bus ();

  mem_req_responder #(
    .LATENCY   (LAT),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_mem [0:WORDS-1];
  int          last_served;

  // Word slot a byte address lands in, wrapping modulo the array size.
  function automatic int word_index(input logic [15:0] addr);
    return (int'(addr) / 2) % WORDS;
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input int port, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata);
    if (port == 0) begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_wr    = wr;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end
  endtask

  task automatic drop_req(input int port);
    if (port == 0) bus.i_req = 1'b0;
    else           bus.d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drop_req(0);
    drop_req(1);
    @(negedge clk);
    rst = 1'b0;
    last_served = 0;
  endtask

  // One round of up to two transactions. Each used port raises its request
  // at the falling edge numbered by its delay; the earlier request wins, a
  // tie goes to the port not served last. A request raised at falling edge t
  // and accepted right away is acknowledged at falling edge t+LAT; the other
  // port is accepted on the first idle edge after that ack.
  task automatic serve(input string tag,
                       input bit use_i, input int dly_i, input logic [15:0] addr_i,
                       input bit use_d, input int dly_d, input logic wr_d,
                       input logic [15:0] addr_d, input logic [15:0] wd_d);
    int          ack_at [2];
    int          dly [2];
    bit          used [2];
    int          first;
    int          second;
    int          last_k;
    logic [15:0] exp_rd;
    logic        exp_busy;

    used[0] = use_i;  used[1] = use_d;
    dly[0]  = dly_i;  dly[1]  = dly_d;
    ack_at[0] = -100; ack_at[1] = -100;

    if (use_i && use_d) begin
      if (dly_i < dly_d)      first = 0;
      else if (dly_d < dly_i) first = 1;
      else                    first = 1 - last_served;
      second = 1 - first;
      ack_at[first]  = dly[first] + LAT;
      ack_at[second] = ((dly[second] > ack_at[first] + 1) ? dly[second] : ack_at[first] + 1) + LAT;
      last_served    = second;
    end else begin
      first = use_d ? 1 : 0;
      ack_at[first] = dly[first] + LAT;
      last_served   = first;
    end
    last_k = ((ack_at[0] > ack_at[1]) ? ack_at[0] : ack_at[1]) + 2;

    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);

      exp_busy = 1'b0;
      for (int p = 0; p < 2; p++)
        if (used[p] && k > ack_at[p] - LAT && k <= ack_at[p]) exp_busy = 1'b1;
      check_output({tag, " busy"}, {15'd0, busy}, {15'd0, exp_busy});

      check_output({tag, " i_ack"}, {15'd0, bus.i_ack}, {15'd0, (k == ack_at[0])});
      exp_rd = (k == ack_at[0]) ? model_mem[word_index(addr_i)] : 16'h0000;
      check_output({tag, " i_rdata"}, bus.i_rdata, exp_rd);

      check_output({tag, " d_ack"}, {15'd0, bus.d_ack}, {15'd0, (k == ack_at[1])});
      exp_rd = (k == ack_at[1] && !wr_d) ? model_mem[word_index(addr_d)] : 16'h0000;
      check_output({tag, " d_rdata"}, bus.d_rdata, exp_rd);

      if (k == ack_at[1] && wr_d) model_mem[word_index(addr_d)] = wd_d;

      if (bus.i_ack || k == ack_at[0]) drop_req(0);
      if (bus.d_ack || k == ack_at[1]) drop_req(1);
      if (use_i && k == dly_i) apply_stimulus(0, 1'b0, addr_i, 16'h0000);
      if (use_d && k == dly_d) apply_stimulus(1, wr_d, addr_d, wd_d);
    end
    drop_req(0);
    drop_req(1);
  endtask

  task automatic write_d(input string tag, input logic [15:0] addr, input logic [15:0] wd);
    serve(tag, 1'b0, 0, 16'h0000, 1'b1, 0, 1'b1, addr, wd);
  endtask

  task automatic read_d(input string tag, input logic [15:0] addr);
    serve(tag, 1'b0, 0, 16'h0000, 1'b1, 0, 1'b0, addr, 16'h0000);
  endtask

  task automatic read_i(input string tag, input logic [15:0] addr);
    serve(tag, 1'b1, 0, addr, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    for (int w = 0; w < WORDS; w++) model_mem[w] = 16'h0000;
    last_served = 0;
    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0000;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = 16'h0000;
    bus.d_wdata = 16'h0000;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    check_output("reset busy",    {15'd0, busy},      16'h0000);
    check_output("reset i_ack",   {15'd0, bus.i_ack}, 16'h0000);
    check_output("reset d_ack",   {15'd0, bus.d_ack}, 16'h0000);
    check_output("reset i_rdata", bus.i_rdata,        16'h0000);
    check_output("reset d_rdata", bus.d_rdata,        16'h0000);
    rst = 1'b0;

    $display("[TB] simultaneous requests after reset");
    serve("tie1", 1'b1, 0, 16'h0002, 1'b1, 0, 1'b1, 16'h0002, 16'h7777);
    serve("tie2", 1'b1, 0, 16'h0002, 1'b1, 0, 1'b0, 16'h0003, 16'h0000);

    $display("[TB] single read");
    write_d("preload", 16'h0020, 16'hBEEF);
    read_i("iread", 16'h0021);

    $display("[TB] write then read");
    write_d("wr40", 16'h0040, 16'h1234);
    read_d("rd40", 16'h0040);

    $display("[TB] address wrap");
    write_d("wrap_wr", 16'h0802, 16'h5A5A);
    read_d("wrap_rd", 16'h0002);

    $display("[TB] reset mid-transaction");
    write_d("old100", 16'h0100, 16'h0BAD);
    @(negedge clk);
    apply_stimulus(1, 1'b1, 16'h0100, 16'hDEAD);
    @(negedge clk);
    check_output("abort busy c1", {15'd0, busy}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    drop_req(1);
    @(negedge clk);
    rst = 1'b0;
    last_served = 0;
    check_output("abort busy c3", {15'd0, busy},      16'h0000);
    check_output("abort d_ack",   {15'd0, bus.d_ack}, 16'h0000);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check_output("abort late d_ack", {15'd0, bus.d_ack}, 16'h0000);
      check_output("abort late busy",  {15'd0, busy},      16'h0000);
    end
    read_d("rd100", 16'h0100);

    $display("[TB] request while busy");
    serve("overlap", 1'b1, 0, 16'h0040, 1'b1, 2, 1'b0, 16'h0020, 16'h0000);

    $display("[TB] randomized traffic");
    for (int j = 0; j < 16; j++)
      write_d("pool", 16'((($urandom_range(0, 31)) << 11) | ((32 + j) << 1)), 16'($urandom));
    for (int n = 0; n < 60; n++) begin
      bit          ui, ud;
      int          sel;
      logic [15:0] ai, ad;
      sel = $urandom_range(0, 2);
      ui  = (sel != 1);
      ud  = (sel != 0);
      ai  = 16'(($urandom_range(0, 31) << 11) | ((32 + $urandom_range(0, 15)) << 1) | $urandom_range(0, 1));
      ad  = 16'(($urandom_range(0, 31) << 11) | ((32 + $urandom_range(0, 15)) << 1) | $urandom_range(0, 1));
      serve("rand", ui, $urandom_range(0, LAT), ai, ud, $urandom_range(0, LAT),
            1'($urandom_range(0, 1)), ad, 16'($urandom));
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
